// File: rtl/tva_pkg.sv
// Shared types and helpers for the MLP output serializer.
// Holds the stream FSM state encoding and the width helper used to size
// the element index and coordinate outputs.
package tva_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Width needed to index n items; never narrower than one bit so that
  // degenerate dimensions (size 1) still produce a legal port.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mlp_out_serializer.sv
// Ping-pong tensor buffer that captures a whole (L,N,E) tensor in one cycle
// and streams it out one element per handshake beat, in ascending flat index
// order, with the (l,n,e) coordinates of each element alongside.
module mlp_out_serializer
  import tva_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH*L*N*E-1:0]      in_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [idx_width(L)-1:0]          m_l,
  output logic [idx_width(N)-1:0]          m_n,
  output logic [idx_width(E)-1:0]          m_e,
  output logic                             m_last_row,
  output logic                             m_last,
  output logic [1:0]                       buf_count,
  output logic                             overflow
);

  localparam int T     = L * N * E;
  localparam int IDX_W = idx_width(T);
  localparam int LW    = idx_width(L);
  localparam int NW    = idx_width(N);
  localparam int EW    = idx_width(E);
  localparam int BUF_W = DATA_WIDTH * T;
  localparam int SEL_W = idx_width(BUF_W);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(T - 1);
  localparam logic [EW-1:0]    LAST_E   = EW'(E - 1);

  // Tensor storage; contents are only meaningful while counted as held.
  logic [BUF_W-1:0] buf_q [2];

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
  logic             overflow_q, overflow_d;
  state_t           state_q, state_d;

  logic             beat;
  logic             final_beat;
  logic             capture;
  logic             drop;

  logic [31:0]      k_w;
  logic [SEL_W-1:0] bit_base;

  // A full buffer pair can still accept a tensor if the final beat frees
  // the reading buffer in the same cycle; the write lands in that buffer
  // on the same edge that moves rd_ptr away from it.
  assign beat       = (state_q == S_STREAM) && m_ready;
  assign final_beat = beat && (elem_idx_q == LAST_IDX);
  assign capture    = in_valid && ((count_q != 2'd2) || final_beat);
  assign drop       = in_valid && !capture;

  // Next-state for pointers, occupancy, element index and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    elem_idx_d = elem_idx_q;
    overflow_d = overflow_q;

    if (capture) begin
      wr_ptr_d = ~wr_ptr_q;
    end

    if (beat) begin
      if (final_beat) begin
        elem_idx_d = '0;
        rd_ptr_d   = ~rd_ptr_q;
      end else begin
        elem_idx_d = elem_idx_q + 1'b1;
      end
    end

    case ({capture, final_beat})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Stream FSM next state: idle until a capture, back to idle only when the
  // last held tensor finishes and nothing new arrives that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (final_beat && !capture && (count_q == 2'd1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers, cleared asynchronously so a mid-stream reset stops output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      elem_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      elem_idx_q <= elem_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Whole-tensor write into the buffer selected by wr_ptr; never touches the buffer being read.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q[wr_ptr_q] <= in_data;
    end
  end

  // Element select and coordinate decode from the flat element index.
  assign k_w      = 32'(elem_idx_q);
  assign bit_base = SEL_W'(k_w * 32'(DATA_WIDTH));

  assign m_data     = buf_q[rd_ptr_q][bit_base +: DATA_WIDTH];
  assign m_e        = EW'(k_w % 32'(E));
  assign m_n        = NW'((k_w / 32'(E)) % 32'(N));
  assign m_l        = LW'(k_w / 32'(N * E));
  assign m_last_row = (m_e == LAST_E);
  assign m_last     = (elem_idx_q == LAST_IDX);

  // m_valid comes straight from the state register, so in_valid cannot reach it combinationally.
  assign m_valid   = (state_q == S_STREAM);
  assign buf_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mlp_out_serializer.sv
// Scoreboard bench for mlp_out_serializer: expected elements are queued when
// a tensor is offered and popped as the DUT hands out beats.
module tb_mlp_out_serializer;

  localparam int DW = 16;
  localparam int L  = 8;
  localparam int N  = 1;
  localparam int E  = 8;
  localparam int T  = L * N * E;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DW*T-1:0]   in_data;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [2:0]        m_l;
  logic [0:0]        m_n;
  logic [2:0]        m_e;
  logic              m_last_row;
  logic              m_last;
  logic [1:0]        buf_count;
  logic              overflow;

  mlp_out_serializer #(
    .DATA_WIDTH(DW),
    .L(L),
    .N(N),
    .E(E)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_l(m_l),
    .m_n(m_n),
    .m_e(m_e),
    .m_last_row(m_last_row),
    .m_last(m_last),
    .buf_count(buf_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  l;
    logic        n;
    logic [2:0]  e;
    logic        lr;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < T; k++) begin
      in_data[k*DW +: DW] = base + 16'(k);
    end
  endtask

  task automatic push_tensor(input logic [15:0] base);
    exp_t x;
    for (int k = 0; k < T; k++) begin
      x.d    = base + 16'(k);
      x.l    = 3'(k / (N * E));
      x.n    = 1'b0;
      x.e    = 3'(k % E);
      x.lr   = ((k % E) == E - 1);
      x.last = (k == T - 1);
      sb.push_back(x);
    end
  endtask

  task automatic pulse(input logic [15:0] base, input bit accept);
    @(posedge clk); #1;
    fill(base);
    in_valid = 1'b1;
    if (accept) push_tensor(base);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_val({tag, "_drained"}, 32'(sb.size()), 32'd0);
    @(negedge clk); #1;
    check_val({tag, "_vld_end"}, 32'(m_valid), 32'd0);
  endtask

  // Beat monitor: compares every handshake against the queue head and checks
  // that stalled outputs hold still.
  bit          stall_prev = 1'b0;
  logic [15:0] stall_data;
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("stall_vld", 32'(m_valid), 32'd1);
        check_val("stall_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check_val("sb_extra_beat", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          x = sb.pop_front();
          check_val("m_data", 32'(m_data), 32'(x.d));
          check_val("m_l", 32'(m_l), 32'(x.l));
          check_val("m_n", 32'(m_n), 32'(x.n));
          check_val("m_e", 32'(m_e), 32'(x.e));
          check_val("m_last_row", 32'(m_last_row), 32'(x.lr));
          check_val("m_last", 32'(m_last), 32'(x.last));
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    in_data  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vld", 32'(m_valid), 32'd0);
    check_val("rst_cnt", 32'(buf_count), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check_val("post_rst_vld", 32'(m_valid), 32'd0);

    // Full-rate stream: 64 beats in 64 consecutive cycles.
    m_ready = 1'b1;
    pulse(16'h0001, 1'b1);
    for (int i = 0; i < T; i++) begin
      @(negedge clk); #1;
      check_val("t2_vld_run", 32'(m_valid), 32'd1);
    end
    @(negedge clk); #1;
    check_val("t2_vld_end", 32'(m_valid), 32'd0);
    check_val("t2_drained", 32'(sb.size()), 32'd0);

    // Toggling ready on the same tensor.
    m_ready = 1'b0;
    pulse(16'h0001, 1'b1);
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
        @(posedge clk); #1;
        m_ready = ~m_ready;
        n++;
      end
    end
    check_val("t3_drained", 32'(sb.size()), 32'd0);
    @(negedge clk); #1;
    check_val("t3_vld_end", 32'(m_valid), 32'd0);

    // Fill both buffers while stalled, then overflow with C.
    m_ready = 1'b0;
    pulse(16'hA000, 1'b1);
    pulse(16'hB000, 1'b1);
    pulse(16'hC000, 1'b0);
    @(negedge clk); #1;
    check_val("t4_cnt", 32'(buf_count), 32'd2);
    check_val("t4_ovf", 32'(overflow), 32'd1);
    check_val("t4_head", 32'(m_data), 32'hA000);
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      @(negedge clk); #1;
      check_val("t4_vld_run", 32'(m_valid), 32'd1);
    end
    @(negedge clk); #1;
    check_val("t4_vld_end", 32'(m_valid), 32'd0);
    check_val("t4_drained", 32'(sb.size()), 32'd0);
    check_val("t4_ovf_sticky", 32'(overflow), 32'd1);

    // Capture coinciding with A's final beat at full occupancy.
    do_reset(2);
    m_ready = 1'b0;
    pulse(16'hA000, 1'b1);
    pulse(16'hB000, 1'b1);
    @(negedge clk); #1;
    check_val("t5_cnt_full", 32'(buf_count), 32'd2);
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (T - 1) @(posedge clk);
    #1;
    check_val("t5_align_last", 32'(m_last), 32'd1);
    check_val("t5_align_data", 32'(m_data), 32'hA03F);
    fill(16'hD000);
    in_valid = 1'b1;
    push_tensor(16'hD000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    check_val("t5_cnt", 32'(buf_count), 32'd2);
    check_val("t5_ovf", 32'(overflow), 32'd0);
    wait_drain("t5", 300);

    // Asynchronous reset mid-stream, then a clean restart.
    m_ready = 1'b1;
    pulse(16'h5000, 1'b1);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check_val("t6_rst_vld", 32'(m_valid), 32'd0);
    check_val("t6_rst_cnt", 32'(buf_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_val("t6_idle_vld", 32'(m_valid), 32'd0);
    check_val("t6_idle_ovf", 32'(overflow), 32'd0);
    pulse(16'h6000, 1'b1);
    wait_drain("t6", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mlp_out_serializer.md
MLP_OUT_SERIALIZER -- requirements
Module: mlp_out_serializer

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 16, meaning the bits per tensor element.
REQ-002 The block SHALL take parameter L, default 8, meaning the sequence length.
REQ-003 The block SHALL take parameter N, default 1, meaning the batch size.
REQ-004 The block SHALL take parameter E, default 8, meaning the embedding width; T = L*N*E elements per tensor.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: one-cycle capture pulse, driven by the MLP out_valid.
REQ-009 The block SHALL have port in_data, input, DATA_WIDTH*T bits: the packed (L,N,E) tensor; element k=l*N*E+n*E+e occupies bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-010 The block SHALL have port m_valid, output, 1 bit: an output element is available.
REQ-011 The block SHALL have port m_ready, input, 1 bit: the downstream accepts the element.
REQ-012 The block SHALL have port m_data, output, DATA_WIDTH bits: the current element.
REQ-013 The block SHALL have ports m_l, m_n and m_e, outputs, $clog2 widths with a minimum of 1 bit: the coordinates of m_data.
REQ-014 The block SHALL have port m_last_row, output, 1 bit: high when e==E-1.
REQ-015 The block SHALL have port m_last, output, 1 bit: high when k==T-1.
REQ-016 The block SHALL have port buf_count, output, 2 bits: the number of tensors held (0..2).
REQ-017 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a tensor is dropped.

Function
REQ-018 Storage SHALL be two tensor buffers (ping-pong), addressed by wr_ptr, rd_ptr and count.
REQ-019 Capture: when in_valid and count<2, in_data SHALL be stored whole into buffer[wr_ptr]; wr_ptr toggles; count increments.
REQ-020 Drop: when in_valid and count==2 with no final beat in the same cycle, in_data SHALL be discarded and overflow set to 1 until reset.
REQ-021 FSM states SHALL be S_IDLE (count==0) and S_STREAM (count>0); S_IDLE->S_STREAM on capture; S_STREAM->S_IDLE on the final beat of the last held tensor with no simultaneous capture.
REQ-022 m_valid SHALL equal (count>0), registered, with no combinational path from in_valid.
REQ-023 m_data/m_l/m_n/m_e/m_last_row/m_last SHALL reflect buffer[rd_ptr] at element index elem_idx, decoded from elem_idx.
REQ-024 A beat SHALL be m_valid&&m_ready; on a beat elem_idx increments, ascending k order.
REQ-025 Final beat (elem_idx==T-1): elem_idx wraps to 0, rd_ptr toggles, count decrements.
REQ-026 While m_valid&&!m_ready, all m_* outputs SHALL hold stable, and m_valid SHALL NOT drop without a beat.
REQ-027 Latency: with in_valid at cycle t and count==0 beforehand, m_valid SHALL be 1 with element 0 at t+1; with m_ready held high, T beats SHALL complete in T consecutive cycles.
REQ-028 Simultaneous final beat and in_valid at count==2: the capture SHALL be accepted into the freed buffer, count stays 2, and overflow is unchanged.
REQ-029 Simultaneous capture and a non-final beat: both SHALL take effect, and the streaming buffer SHALL be unaffected by the write.
REQ-030 Back-to-back tensors SHALL stream with no idle cycle between the final beat of one and element 0 of the next.

Reset
REQ-031 On rst the block SHALL clear count, wr_ptr, rd_ptr, elem_idx, overflow and m_valid to 0 and enter S_IDLE, asynchronously, including mid-stream.
REQ-032 After reset is released the block SHALL capture on the next in_valid, starting from element 0.
REQ-033 Buffer contents SHALL NOT require reset.

Structure
REQ-034 Shared package tva_pkg SHALL hold the state_t enum {S_IDLE,S_STREAM} and an elem-index/coordinate width helper function.
REQ-035 The block SHALL be a single module with no sub-module; the element select is an indexed part-select on buffer[rd_ptr].

Verification
REQ-036 The bench SHALL drive rst=1 for 3 cycles -> m_valid=0, buf_count=0, overflow=0.
REQ-037 The bench SHALL set element k=k+1 (0x0001..0x0040), pulse in_valid once and hold m_ready=1 -> 64 beats in 64 cycles from t+1, m_last only on 0x0040 with m_l=7 and m_e=7, and m_last_row on every 8th beat.
REQ-038 The bench SHALL toggle m_ready every cycle on the same tensor -> m_data is stable while stalled, order is 0x0001..0x0040, and no duplicates or gaps occur.
REQ-039 The bench SHALL hold m_ready=0 and pulse tensors A (0xA000+k), B (0xB000+k), then C -> buf_count=2, overflow=1, and C is dropped; then m_ready=1 -> A fully, then B, with no gap, then m_valid=0.
REQ-040 The bench SHALL drive in_valid with D (0xD000+k) in the same cycle as the final beat of A at buf_count=2 -> D accepted, overflow=0, buf_count=2, and output is B then D.
REQ-041 The bench SHALL assert rst mid-stream at beat 10 -> m_valid=0 and buf_count=0 immediately; a new capture afterwards streams from element 0.
